// File: rtl/bus_arb_pkg.sv
// Shared types for the pipeline bus arbiter and other two-master arbiters.
//   arb_state_t : arbiter FSM states (IDLE, GRANT_I, GRANT_D)
//   requester_t : which master owns or last owned the bus
//   bus_req_t   : a latched generic-bus request, sized by the package defaults
//   rr_pick     : two-way round-robin selection
package bus_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    typedef struct packed {
        logic                  ren;
        logic                  wen;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [BE_W_DEF-1:0]   byte_en;
    } bus_req_t;

    // On a tie the master that did not win last time is picked.
    // With no request the result is meaningless and must be gated by the caller.
    function automatic requester_t rr_pick(input logic req_i,
                                           input logic req_d,
                                           input requester_t last);
        requester_t pick;
        if (req_i && req_d) begin
            pick = (last == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            pick = REQ_D;
        end else begin
            pick = REQ_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter with its own last-grant register.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : arbitration window; grants and last-grant updates only happen here
//   req0_i/req1_i : requests (req0 = REQ_I side, req1 = REQ_D side)
//   gnt0_o/gnt1_o : one-hot grant, combinational, zero when en_i is low
// last-grant resets to REQ_I so REQ_D wins the first tie.
module rr_arbiter2
    import bus_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    requester_t last_q, last_d;
    requester_t pick;
    logic       any_req;

    always_comb begin
        any_req = req0_i | req1_i;
        pick    = rr_pick(req0_i, req1_i, last_q);
        gnt0_o  = en_i & any_req & (pick == REQ_I);
        gnt1_o  = en_i & any_req & (pick == REQ_D);
        last_d  = last_q;
        if (en_i && any_req) begin
            last_d = pick;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= REQ_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/pipeline_bus_arbiter.sv
// Shares one downstream generic memory bus between the instruction-fetch
// master (i_*) and the memory-stage data master (d_*).
// Ports:
//   CLK, nRST            : clock, asynchronous active-low reset
//   i_ren, i_addr        : instruction read request
//   i_busy, i_rdata      : instruction completion strobe (low for one cycle) and read data
//   d_ren, d_wen, d_addr, d_wdata, d_byte_en : data request
//   d_busy, d_rdata      : data completion strobe and read data
//   m_ren, m_wen, m_addr, m_wdata, m_byte_en : downstream request (from the latched copy only)
//   m_busy, m_rdata      : downstream busy (low = completes this cycle) and read data
//   dbg_state            : current FSM state (arb_state_t encoding)
// Handshake: a master holds its request while its busy is high; a transaction
// is latched at grant and completes in the first grant cycle with m_busy low.
// A master that drops its request mid-transaction has its completion swallowed.
module pipeline_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                i_ren,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_busy,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_en,
    output logic                d_busy,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_ren,
    output logic                m_wen,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_byte_en,
    input  logic                m_busy,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic [1:0]          dbg_state
);

    arb_state_t          state_q, state_d;
    logic                ren_q, ren_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    // Sticky: the owning master let go of its request at some point during the grant.
    logic                drop_q, drop_d;

    logic i_act, d_act, in_idle, gnt_i, gnt_d;

    assign i_act   = i_ren;
    assign d_act   = d_ren | d_wen;
    assign in_idle = (state_q == IDLE);

    rr_arbiter2 u_rr (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .en_i   (in_idle),
        .req0_i (i_act),
        .req1_i (d_act),
        .gnt0_o (gnt_i),
        .gnt1_o (gnt_d)
    );

    always_comb begin
        state_d = state_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        drop_d  = drop_q;
        i_busy  = 1'b1;
        d_busy  = 1'b1;
        i_rdata = '0;
        d_rdata = '0;

        case (state_q)
            IDLE: begin
                // m_busy is deliberately ignored here.
                if (gnt_d) begin
                    state_d = GRANT_D;
                    // Read+write together is treated as a write.
                    ren_d   = d_ren & ~d_wen;
                    wen_d   = d_wen;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    be_d    = d_byte_en;
                    drop_d  = 1'b0;
                end else if (gnt_i) begin
                    state_d = GRANT_I;
                    ren_d   = 1'b1;
                    wen_d   = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    be_d    = '1;
                    drop_d  = 1'b0;
                end
            end
            GRANT_I: begin
                i_rdata = m_rdata;
                if (!i_act) begin
                    drop_d = 1'b1;
                end
                if (!m_busy) begin
                    state_d = IDLE;
                    i_busy  = drop_q | ~i_act;
                end
            end
            GRANT_D: begin
                d_rdata = m_rdata;
                if (!d_act) begin
                    drop_d = 1'b1;
                end
                if (!m_busy) begin
                    state_d = IDLE;
                    d_busy  = drop_q | ~d_act;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            drop_q  <= drop_d;
        end
    end

    // The strobes are gated in IDLE; address/data simply show the last latched request.
    assign m_ren     = ren_q & ~in_idle;
    assign m_wen     = wen_q & ~in_idle;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign m_byte_en = be_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_bus_arbiter.sv
module tb_pipeline_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int OW = 2 + AW + DW + BW + 2 + 2 * DW;

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          i_ren = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_busy;
    logic [DW-1:0] i_rdata;
    logic          d_ren = 1'b0;
    logic          d_wen = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [BW-1:0] d_byte_en = '0;
    logic          d_busy;
    logic [DW-1:0] d_rdata;
    logic          m_ren, m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_byte_en;
    logic          m_busy = 1'b1;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    dbg_state;

    always #5 CLK = ~CLK;

    pipeline_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_ren(i_ren), .i_addr(i_addr), .i_busy(i_busy), .i_rdata(i_rdata),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_en(d_byte_en), .d_busy(d_busy), .d_rdata(d_rdata),
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byte_en(m_byte_en), .m_busy(m_busy), .m_rdata(m_rdata),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected downstream addresses, in grant order.
    logic [DW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Transaction-level view: who owns the bus (0 none, 1 instr, 2 data),
    // who won most recently, and the request captured when ownership began.
    int            mdl_owner;
    int            mdl_last;
    bit            mdl_drop;
    bit            mdl_ren, mdl_wen;
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_wdata;
    logic [BW-1:0] mdl_be;
    logic [OW-1:0] exp_all, obs_all;

    task automatic model_reset();
        mdl_owner = 0;
        mdl_last  = 1;
        mdl_drop  = 1'b0;
        mdl_ren   = 1'b0;
        mdl_wen   = 1'b0;
        mdl_addr  = '0;
        mdl_wdata = '0;
        mdl_be    = '0;
    endtask

    // Let combinational outputs settle, then form expected and observed bundles.
    // Read data is masked where it is a don't-care (granted but not delivering).
    task automatic settle();
        bit            done, i_ok, d_ok;
        logic [DW-1:0] e_ird, e_drd, o_ird, o_drd;
        #1;
        done  = (mdl_owner != 0) && !m_busy;
        i_ok  = done && (mdl_owner == 1) && !mdl_drop && i_ren;
        d_ok  = done && (mdl_owner == 2) && !mdl_drop && (d_ren || d_wen);
        e_ird = (mdl_owner == 1) ? m_rdata : '0;
        e_drd = (mdl_owner == 2) ? m_rdata : '0;
        o_ird = i_rdata;
        o_drd = d_rdata;
        if (mdl_owner == 1 && !i_ok) begin e_ird = '0; o_ird = '0; end
        if (mdl_owner == 2 && !d_ok) begin e_drd = '0; o_drd = '0; end
        exp_all = {(mdl_owner != 0) && mdl_ren, (mdl_owner != 0) && mdl_wen,
                   mdl_addr, mdl_wdata, mdl_be, !i_ok, !d_ok, e_ird, e_drd};
        obs_all = {m_ren, m_wen, m_addr, m_wdata, m_byte_en, i_busy, d_busy, o_ird, o_drd};
    endtask

    // Take one clock edge and move the model forward with the inputs it saw.
    task automatic advance();
        int win;
        @(posedge CLK);
        if (mdl_owner == 0) begin
            win = 0;
            if (i_ren && (d_ren || d_wen)) win = (mdl_last == 2) ? 1 : 2;
            else if (d_ren || d_wen)       win = 2;
            else if (i_ren)                win = 1;
            if (win == 2) begin
                mdl_ren   = d_ren && !d_wen;
                mdl_wen   = d_wen;
                mdl_addr  = d_addr;
                mdl_wdata = d_wdata;
                mdl_be    = d_byte_en;
            end else if (win == 1) begin
                mdl_ren   = 1'b1;
                mdl_wen   = 1'b0;
                mdl_addr  = i_addr;
                mdl_wdata = '0;
                mdl_be    = '1;
            end
            if (win != 0) begin
                mdl_owner = win;
                mdl_last  = win;
                mdl_drop  = 1'b0;
            end
        end else if (!m_busy) begin
            mdl_owner = 0;
        end else if ((mdl_owner == 1 && !i_ren) || (mdl_owner == 2 && !(d_ren || d_wen))) begin
            mdl_drop = 1'b1;
        end
        @(negedge CLK);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_quiet();
        i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        m_busy = 1'b1; m_rdata = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [DW-1:0] rd;
        nRST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            i_ren = 1'($urandom); d_ren = 1'($urandom); d_wen = 1'($urandom);
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_byte_en = 4'($urandom); m_busy = 1'($urandom); m_rdata = $urandom;
            #1;
            checks++;
            if ({m_ren, m_wen, m_addr, m_wdata, m_byte_en, i_busy, d_busy, i_rdata, d_rdata, dbg_state}
                !== {2'b00, {AW{1'b0}}, {DW{1'b0}}, {BW{1'b0}}, 2'b11, {DW{1'b0}}, {DW{1'b0}}, 2'b00}) begin
                errors++;
                $display("FAIL reset_hold c%0d: m_ren=%b m_wen=%b m_addr=%h i_busy=%b d_busy=%b, required all zero and busy=1",
                         c, m_ren, m_wen, m_addr, i_busy, d_busy);
            end
        end
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        drive_quiet();
        i_ren = 1'b1; i_addr = 32'h8000_0000;
        settle();
        checks++;
        if (obs_all !== exp_all) begin
            errors++; $display("FAIL reset_first_idle: got %h required %h", obs_all, exp_all);
        end
        advance();
        rd = $urandom; m_rdata = rd; m_busy = 1'b0;
        settle();
        checks++;
        if (m_ren !== 1'b1 || m_wen !== 1'b0 || m_addr !== 32'h8000_0000 || m_byte_en !== 4'hF) begin
            errors++;
            $display("FAIL first_grant: m_ren=%b m_wen=%b m_addr=%h be=%h, required 1 0 80000000 f",
                     m_ren, m_wen, m_addr, m_byte_en);
        end
        checks++;
        if (i_busy !== 1'b0 || i_rdata !== rd || d_busy !== 1'b1) begin
            errors++;
            $display("FAIL first_complete: i_busy=%b i_rdata=%h d_busy=%b, required 0 %h 1", i_busy, i_rdata, d_busy, rd);
        end
        advance();
        i_ren = 1'b0;
        settle();
        checks++;
        if (m_ren !== 1'b0 || i_busy !== 1'b1) begin
            errors++; $display("FAIL bubble_after_complete: m_ren=%b i_busy=%b, required 0 1", m_ren, i_busy);
        end
        advance();
    endtask

    task automatic test_contention();
        logic [AW-1:0] ia;
        int grants = 0;
        ia = 32'h0000_2000;
        drive_quiet();
        exp_q.push_back(32'h100); exp_q.push_back(ia);
        exp_q.push_back(32'h100); exp_q.push_back(ia);
        i_ren = 1'b1; i_addr = ia;
        d_wen = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_byte_en = 4'hF;
        m_busy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            m_rdata = $urandom;
            settle();
            checks++;
            if (obs_all !== exp_all) begin
                errors++; $display("FAIL contention_model c%0d: got %h required %h", c, obs_all, exp_all);
            end
            if (m_ren || m_wen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL contention_order c%0d: extra grant to %h, required none", c, m_addr);
                end else if (m_addr !== exp_q[0]) begin
                    errors++; $display("FAIL contention_order c%0d: grant to %h, required %h", c, m_addr, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                if (grants == 0) begin
                    checks++;
                    if (m_wen !== 1'b1 || m_ren !== 1'b0 || m_wdata !== 32'hDEAD_BEEF || m_byte_en !== 4'hF) begin
                        errors++;
                        $display("FAIL contention_first_data: m_wen=%b m_ren=%b m_wdata=%h be=%h, required 1 0 deadbeef f",
                                 m_wen, m_ren, m_wdata, m_byte_en);
                    end
                end
                grants++;
            end
            advance();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL contention_count: %0d grants missing, required 0", exp_q.size());
            exp_q.delete();
        end
        drive_quiet();
    endtask

    task automatic test_wait_states();
        logic [AW-1:0] a;
        logic [DW-1:0] rd;
        a = $urandom;
        drive_quiet();
        d_ren = 1'b1; d_addr = a; d_byte_en = 4'($urandom);
        m_busy = 1'b0;                     // ignored while idle
        settle();
        advance();
        for (int c = 1; c <= 6; c++) begin
            rd = $urandom; m_rdata = rd;
            m_busy = (c < 6);
            d_addr = $urandom;             // must not leak to the bus
            settle();
            checks++;
            if (obs_all !== exp_all) begin
                errors++; $display("FAIL wait_model c%0d: got %h required %h", c, obs_all, exp_all);
            end
            checks++;
            if (m_ren !== 1'b1 || m_wen !== 1'b0 || m_addr !== a || i_busy !== 1'b1 ||
                d_busy !== (c < 6) || (c == 6 && d_rdata !== rd)) begin
                errors++;
                $display("FAIL wait_cycle c%0d: m_ren=%b m_addr=%h d_busy=%b d_rdata=%h, required 1 %h %b %h",
                         c, m_ren, m_addr, d_busy, d_rdata, a, (c < 6), rd);
            end
            advance();
        end
        drive_quiet();
        settle();
        checks++;
        if (m_ren !== 1'b0 || d_busy !== 1'b1) begin
            errors++; $display("FAIL wait_idle: m_ren=%b d_busy=%b, required 0 1", m_ren, d_busy);
        end
        advance();
    endtask

    task automatic test_abort();
        logic [AW-1:0] a;
        a = 32'h0000_4440;
        drive_quiet();
        i_ren = 1'b1; i_addr = a;
        settle();
        advance();
        i_ren = 1'b0; i_addr = 32'h0000_9990;
        for (int c = 1; c <= 4; c++) begin
            m_busy = (c < 4);
            m_rdata = $urandom;
            settle();
            checks++;
            if (obs_all !== exp_all) begin
                errors++; $display("FAIL abort_model c%0d: got %h required %h", c, obs_all, exp_all);
            end
            checks++;
            if (m_ren !== 1'b1 || m_addr !== a || i_busy !== 1'b1) begin
                errors++;
                $display("FAIL abort_cycle c%0d: m_ren=%b m_addr=%h i_busy=%b, required 1 %h 1", c, m_ren, m_addr, i_busy, a);
            end
            advance();
        end
        m_busy = 1'b1;
        settle();
        checks++;
        if (m_ren !== 1'b0 || i_busy !== 1'b1) begin
            errors++; $display("FAIL abort_idle: m_ren=%b i_busy=%b, required 0 1", m_ren, i_busy);
        end
        advance();
    endtask

    task automatic test_read_write_both();
        drive_quiet();
        d_ren = 1'b1; d_wen = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_byte_en = 4'h3;
        settle();
        advance();
        m_busy = 1'b0;
        settle();
        checks++;
        if (m_wen !== 1'b1 || m_ren !== 1'b0 || m_byte_en !== 4'h3 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL rw_both: m_wen=%b m_ren=%b be=%h d_busy=%b, required 1 0 3 0", m_wen, m_ren, m_byte_en, d_busy);
        end
        checks++;
        if (obs_all !== exp_all) begin
            errors++; $display("FAIL rw_both_model: got %h required %h", obs_all, exp_all);
        end
        advance();
        drive_quiet();
        settle();
        advance();
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        drive_quiet();
        d_ren = 1'b1; d_addr = 32'h0000_0F00;
        settle();
        advance();
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if ({m_ren, m_wen, m_addr, m_wdata, m_byte_en, i_busy, d_busy, i_rdata, d_rdata}
            !== {2'b00, {AW{1'b0}}, {DW{1'b0}}, {BW{1'b0}}, 2'b11, {DW{1'b0}}, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid: m_ren=%b m_wen=%b m_addr=%h d_busy=%b d_rdata=%h, required 0 0 0 1 0",
                     m_ren, m_wen, m_addr, d_busy, d_rdata);
        end
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        drive_quiet();
        a = $urandom;
        i_ren = 1'b1; i_addr = a;
        settle();
        advance();
        settle();
        checks++;
        if (m_ren !== 1'b1 || m_addr !== a || i_busy !== 1'b1) begin
            errors++; $display("FAIL reset_mid_regrant: m_ren=%b m_addr=%h i_busy=%b, required 1 %h 1", m_ren, m_addr, i_busy, a);
        end
        m_busy = 1'b0;
        settle();
        advance();
        drive_quiet();
        settle();
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            i_ren     = ($urandom_range(0, 3) != 0);
            d_ren     = ($urandom_range(0, 2) == 0);
            d_wen     = ($urandom_range(0, 2) == 0);
            i_addr    = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            d_byte_en = 4'($urandom);
            m_busy    = ($urandom_range(0, 2) != 0);
            m_rdata   = $urandom;
            settle();
            checks++;
            if (obs_all !== exp_all) begin
                errors++; $display("FAIL random_model c%0d: got %h required %h", c, obs_all, exp_all);
            end
            advance();
        end
        drive_quiet();
        m_busy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (obs_all !== exp_all) begin
                errors++; $display("FAIL random_drain c%0d: got %h required %h", c, obs_all, exp_all);
            end
            advance();
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_contention();
        test_wait_states();
        test_abort();
        test_read_write_both();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
